// File: rtl/controller_pkg.sv
// Shared decode constants for the MIPS-subset controller: opcodes, functs,
// control-field codes and instruction field positions.
package controller_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10,
        ALU_LUI = 2'b11
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC8 = 2'b10
    } wd_sel_t;

    // One-hot instruction identity; all-zero means unsupported encoding.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_class_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[FUNCT_HI:FUNCT_LO];
    endfunction

endpackage

// File: rtl/controller_if.sv
// Instruction-in / control-out bundle between a pipeline stage and its decoder.
interface controller_if;
    logic [31:0] instruc;
    logic [1:0]  alu_ctrl;
    logic        alu_src;
    logic        ext_sign;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
    logic        illegal_seen;

    modport master (
        output instruc,
        input  alu_ctrl, alu_src, ext_sign, reg_write, reg_dst, wd_sel,
        input  mem_write, branch, jump, jump_reg, illegal, illegal_seen
    );

    modport slave (
        input  instruc,
        output alu_ctrl, alu_src, ext_sign, reg_write, reg_dst, wd_sel,
        output mem_write, branch, jump, jump_reg, illegal, illegal_seen
    );
endinterface

// File: rtl/controller_instr_class_decode.sv
// Recognises each supported encoding and raises exactly one identity flag,
// or none for an unsupported word.
module controller_instr_class_decode
    import controller_pkg::*;
(
    input  logic [31:0]  instruc,
    output instr_class_t cls
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       rtype;

    assign op    = opcode_of(instruc);
    assign fn    = funct_of(instruc);
    assign rtype = (op == OP_RTYPE);

    always_comb begin
        cls      = '0;
        cls.nop  = (instruc == 32'h0000_0000);
        // The all-zero word is nop even though its funct field is not addu/subu/jr.
        cls.addu = rtype && (fn == FN_ADDU);
        cls.subu = rtype && (fn == FN_SUBU);
        cls.jr   = rtype && (fn == FN_JR);
        cls.ori  = (op == OP_ORI);
        cls.lui  = (op == OP_LUI);
        cls.lw   = (op == OP_LW);
        cls.sw   = (op == OP_SW);
        cls.beq  = (op == OP_BEQ);
        cls.j    = (op == OP_J);
        cls.jal  = (op == OP_JAL);
    end

endmodule

// File: rtl/controller.sv
// Combinational MIPS-subset decoder: identity flags feed an OR-plane of
// control signals, plus a sticky record of unsupported encodings.
module controller
    import controller_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    controller_if.slave   bus
);

    instr_class_t cls;

    controller_instr_class_decode u_class (
        .instruc (bus.instruc),
        .cls     (cls)
    );

    always_comb begin
        bus.alu_ctrl  = ALU_ADD;
        bus.reg_dst   = DST_RT;
        bus.wd_sel    = WD_ALU;

        if (cls.lui)
            bus.alu_ctrl = ALU_LUI;
        else if (cls.ori)
            bus.alu_ctrl = ALU_OR;
        else if (cls.subu || cls.beq)
            bus.alu_ctrl = ALU_SUB;

        if (cls.jal)
            bus.reg_dst = DST_RA;
        else if (cls.addu || cls.subu)
            bus.reg_dst = DST_RD;

        if (cls.jal)
            bus.wd_sel = WD_PC8;
        else if (cls.lw)
            bus.wd_sel = WD_MEM;

        bus.alu_src   = cls.ori | cls.lui | cls.lw | cls.sw;
        bus.ext_sign  = cls.lw | cls.sw | cls.beq;
        bus.reg_write = cls.addu | cls.subu | cls.ori | cls.lui | cls.lw | cls.jal;
        bus.mem_write = cls.sw;
        bus.branch    = cls.beq;
        bus.jump      = cls.j | cls.jal;
        bus.jump_reg  = cls.jr;
        bus.illegal   = ~|cls;
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus.illegal_seen <= 1'b0;
        else
            bus.illegal_seen <= bus.illegal_seen | bus.illegal;
    end

endmodule

// File: tb/tb_controller.sv
// Directed and randomized checks of the decoder against a table-style
// reference model of the instruction subset.
module tb_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    bit   model_seen;

    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {alu_ctrl, alu_src, ext_sign, reg_write, reg_dst, wd_sel, mem_write, branch, jump, jump_reg, illegal}
    function automatic logic [13:0] model(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] ac, rd, wd;
        logic       src, sx, rw, mw, br, jp, jr, ill;
        op = w[31:26];
        fn = w[5:0];
        ac = 2'b00; rd = 2'b00; wd = 2'b00;
        src = 0; sx = 0; rw = 0; mw = 0; br = 0; jp = 0; jr = 0; ill = 0;
        if (w == 32'h0) begin
        end else if (op == 6'b000000) begin
            case (fn)
                6'b100001: begin rw = 1; rd = 2'b01; ac = 2'b00; end
                6'b100011: begin rw = 1; rd = 2'b01; ac = 2'b01; end
                6'b001000: jr = 1;
                default:   ill = 1;
            endcase
        end else begin
            case (op)
                6'b001101: begin rw = 1; src = 1; ac = 2'b10; end
                6'b001111: begin rw = 1; src = 1; ac = 2'b11; end
                6'b100011: begin rw = 1; src = 1; sx = 1; wd = 2'b01; end
                6'b101011: begin mw = 1; src = 1; sx = 1; end
                6'b000100: begin br = 1; sx = 1; ac = 2'b01; end
                6'b000010: jp = 1;
                6'b000011: begin jp = 1; rw = 1; rd = 2'b10; wd = 2'b10; end
                default:   ill = 1;
            endcase
        end
        return {ac, src, sx, rw, rd, wd, mw, br, jp, jr, ill};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.alu_ctrl, bus.alu_src, bus.ext_sign, bus.reg_write, bus.reg_dst,
                bus.wd_sel, bus.mem_write, bus.branch, bus.jump, bus.jump_reg, bus.illegal};
    endfunction

    task automatic apply(input string tag, input logic [31:0] w, input logic rst);
        logic [13:0] exp;
        @(negedge clk);
        bus.instruc = w;
        reset       = rst;
        exp         = model(w);
        #1;
        check_val({tag, " decode"}, 32'(observed()), 32'(exp));
        @(posedge clk);
        model_seen = rst ? 1'b0 : (model_seen | exp[0]);
        #1;
        check_val({tag, " illegal_seen"}, 32'(bus.illegal_seen), 32'(model_seen));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0]  ops [8];
        logic [5:0]  fns [4];
        ops = '{6'b001101, 6'b001111, 6'b100011, 6'b101011,
                6'b000100, 6'b000010, 6'b000011, 6'b000000};
        fns = '{6'b100001, 6'b100011, 6'b001000, 6'b100000};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:26] = ops[$urandom_range(0, 7)];
            1: begin
                w[31:26] = 6'b000000;
                w[5:0]   = fns[$urandom_range(0, 3)];
            end
            2: begin
                w[31:26] = 6'b000000;
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        model_seen  = 1'b0;
        reset       = 1'b1;
        bus.instruc = 32'h0;

        apply("reset",  32'h0000_0000, 1'b1);
        apply("addu",   32'h0022_1821, 1'b0);
        apply("ori",    32'h3422_0010, 1'b0);
        apply("lui",    32'h3C01_1234, 1'b0);
        apply("lw",     32'h8C22_0004, 1'b0);
        apply("sw",     32'hAC22_0004, 1'b0);
        apply("beq",    32'h1022_0003, 1'b0);
        apply("j",      32'h0800_0010, 1'b0);
        apply("jal",    32'h0C00_0010, 1'b0);
        apply("jr",     32'h03E0_0008, 1'b0);
        apply("subu",   32'h0022_1823, 1'b0);
        apply("nop",    32'h0000_0000, 1'b0);
        apply("add",    32'h0022_1820, 1'b0);
        apply("ones_rst", 32'hFFFF_FFFF, 1'b1);
        apply("ones",   32'hFFFF_FFFF, 1'b0);
        apply("legal_after", 32'h0022_1821, 1'b0);
        apply("clear",  32'h0000_0000, 1'b1);

        for (int i = 0; i < 400; i++)
            apply("rand", rand_word(), ($urandom_range(0, 19) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Instruction decoder for the 5-stage MIPS pipeline (subset: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop).
- Maps a 32-bit instruction word to datapath control signals. Each stage (D/E/M/W) instantiates its own copy on its stage instruction; the EX stage uses alu_ctrl/alu_src.
- Decode is purely combinational. A clocked sticky status bit records any unsupported encoding.

Parameters:
- none

Ports:
- clk  input  1  system clock; only the sticky status register uses it
- reset  input  1  synchronous, active-high reset
- instruc  input  32  instruction word; opcode = [31:26], funct = [5:0]
- alu_ctrl  output  2  00 add, 01 sub, 10 or, 11 lui (B[15:0] shifted into bits [31:16], low half 0)
- alu_src  output  1  1 = ALU B operand comes from the extended immediate; 0 = from the forwarded rt value
- ext_sign  output  1  1 = sign-extend imm16; 0 = zero-extend
- reg_write  output  1  GPR write enable
- reg_dst  output  2  destination select: 00 rt, 01 rd, 10 $31
- wd_sel  output  2  writeback data select: 00 ALU result, 01 data memory, 10 PC+8
- mem_write  output  1  data memory store enable
- branch  output  1  beq: take the branch when rs == rt
- jump  output  1  j/jal: target = {PC+4[31:28], instr_index, 2'b00}
- jump_reg  output  1  jr: target = GPR[rs]
- illegal  output  1  combinational: current word is not a supported encoding
- illegal_seen  output  1  registered sticky copy of illegal

Behaviour:
- All outputs except illegal_seen are combinational in instruc, with zero latency. Unlisted signals are 0.
- Encodings and asserted signals:
  - addu: op 000000, funct 100001 -> reg_write, reg_dst=01, alu_ctrl=00.
  - subu: op 000000, funct 100011 -> reg_write, reg_dst=01, alu_ctrl=01.
  - jr: op 000000, funct 001000 -> jump_reg.
  - nop: word 0x00000000 -> all outputs 0, illegal=0.
  - ori: op 001101 -> reg_write, alu_src, alu_ctrl=10, ext_sign=0.
  - lui: op 001111 -> reg_write, alu_src, alu_ctrl=11, ext_sign=0.
  - lw: op 100011 -> reg_write, alu_src, ext_sign, alu_ctrl=00, wd_sel=01.
  - sw: op 101011 -> mem_write, alu_src, ext_sign, alu_ctrl=00.
  - beq: op 000100 -> branch, ext_sign, alu_ctrl=01.
  - j: op 000010 -> jump.
  - jal: op 000011 -> jump, reg_write, reg_dst=10, wd_sel=10.
- Any other word, including op 000000 with any other funct (other than the all-zero nop):
  - all control outputs are 0, so the instruction behaves as a nop;
  - illegal=1.
- The decoder does not inspect register fields. reg_write stays 1 even when the destination is $0; the register file discards writes to $0.
- illegal_seen:
  - on posedge clk, reset=1 forces 0;
  - otherwise illegal_seen <= illegal_seen | illegal;
  - it stays 1 until the next reset;
  - when reset and an illegal word coincide in the same cycle, reset wins.
- The decode outputs do not depend on reset. Reset applies only to illegal_seen.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - alu_ctrl codes (ADD/SUB/OR/LUI);
  - reg_dst codes (RT/RD/RA);
  - wd_sel codes (ALU/MEM/PC8);
  - instruction field bit ranges (rs [25:21], rt [20:16], rd [15:11]).
- Optional sub-module: instr_class_decode, which produces one-hot instruction-identity flags. Those flags feed an OR-plane that generates the control signals, and the same flags drive illegal.

Test Plan:
- addu 0x00221821 -> reg_write=1, reg_dst=01, alu_ctrl=00, alu_src=0, mem_write=0, illegal=0.
- ori 0x34220010, then lui 0x3C011234 -> ori: alu_src=1, ext_sign=0, alu_ctrl=10. lui: alu_ctrl=11, reg_write=1.
- lw 0x8C220004 / sw 0xAC220004 -> lw: wd_sel=01, reg_write=1, ext_sign=1. sw: mem_write=1, reg_write=0, alu_ctrl=00.
- beq 0x10220003, j 0x08000010, jal 0x0C000010, jr 0x03E00008 -> respectively branch=1 with alu_ctrl=01; jump=1; jump=1 with reg_dst=10, wd_sel=10, reg_write=1; jump_reg=1.
- nop 0x00000000, then add (funct 100000) 0x00221820 -> nop: all 0, illegal=0. add: all controls 0, illegal=1, and illegal_seen=1 after the next posedge.
- Assert reset for one cycle while 0xFFFFFFFF is applied -> illegal_seen=0 after that edge. Keep the word applied with reset=0 -> illegal_seen=1 after the next edge. Then apply a legal word -> illegal_seen stays 1.
